dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the single-cycle processor and an external loader/debug port that preloads or inspects data memory. It sits between the processor's memory signals (`ALUResult`, `WriteData`, `MemWrite`, `ReadData`) and `dmem`. The CPU has priority by default. An aging counter and an optional locked burst guarantee loader progress. The arbiter stalls the CPU whenever the loader takes a cycle the CPU wanted.

## Interface
Parameters:
- `DATA_W`, 32, data and address width
- `MAX_WAIT`, 4, maximum consecutive cycles a pending loader request may be refused
- `BURST_MAX`, 8, maximum beats in one locked loader burst (≥1)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU performs an ldr/str this cycle
- `cpu_we`  in  1  CPU store (MemWrite)
- `cpu_addr`  in  DATA_W  CPU address (ALUResult)
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_rdata`  out  DATA_W  CPU load data
- `cpu_stall`  out  1  CPU must hold PC and suppress all architectural writes this cycle
- `ld_valid`  in  1  loader request valid
- `ld_ready`  out  1  loader granted this cycle
- `ld_we`  in  1  loader write
- `ld_lock`  in  1  request or continue a locked burst
- `ld_addr`  in  DATA_W  loader address
- `ld_wdata`  in  DATA_W  loader write data
- `ld_rdata`  out  DATA_W  loader read data, registered
- `ld_rvalid`  out  1  pulses for one cycle when `ld_rdata` is valid
- `mem_we`  out  1  to `dmem` `wr_en`
- `mem_addr`  out  DATA_W  to `dmem` `addr`
- `mem_wdata`  out  DATA_W  to `dmem` `wr_data`
- `mem_rdata`  in  DATA_W  from `dmem` `rd_data` (combinational read)

## Operation
- States: `ARB_CPU` (default) and `ARB_LOCK` (loader owns memory).
- Grant is combinational, `grant_ld`:
  - In `ARB_CPU`: `ld_valid && (!cpu_req || wait_cnt == MAX_WAIT)`.
  - In `ARB_LOCK`: `ld_valid`.
- Outputs derived from the grant:
  - `ld_ready = grant_ld && rst`.
  - `cpu_stall = cpu_req && grant_ld`.
- Memory mux:
  - When `grant_ld`: `mem_addr/mem_wdata` come from the loader and `mem_we = ld_we`.
  - Otherwise they come from the CPU and `mem_we = cpu_req && cpu_we`.
  - `mem_we` is forced to 0 while `rst` is low.
- `cpu_rdata = mem_rdata` always. The CPU ignores it while stalled.
- A loader beat is `ld_valid && ld_ready`. On a read beat, `ld_rdata <= mem_rdata` and `ld_rvalid <= 1` on the next edge. Otherwise `ld_rvalid <= 0`.
- `wait_cnt`:
  - Cleared on a beat or when `!ld_valid`.
  - Otherwise increments, saturating at `MAX_WAIT`.
- Transition `ARB_CPU` → `ARB_LOCK`: on a beat with `ld_lock=1` and `BURST_MAX>1`. `burst_cnt` is set to 1.
- In `ARB_LOCK`, each beat increments `burst_cnt`. Exit to `ARB_CPU` when any of these holds:
  - a beat occurs with `ld_lock=0`;
  - a beat brings `burst_cnt` to `BURST_MAX`;
  - `ld_valid=0` in a cycle.
- On exit `burst_cnt` clears, and `wait_cnt` clears because a beat just occurred.
- With no requester active: `mem_we=0`, and the address follows the CPU.

## Timing
- Grant, stall and memory mux have zero latency and are combinational in the same cycle.
- Writes commit at the rising edge ending the beat cycle.
- Loader read latency: exactly one cycle (`ld_rvalid` in cycle N+1 for a beat in cycle N).
- A continuously requesting loader waits at most `MAX_WAIT` refused cycles, then is granted.
- The CPU stalls at most `BURST_MAX` consecutive cycles per burst. After a burst exits, the CPU gets at least one cycle before the loader can win again through aging, since `wait_cnt` restarts at 0.
- Reset values: state `ARB_CPU`, `wait_cnt=0`, `burst_cnt=0`, `ld_rdata=0`, `ld_rvalid=0`. `ld_ready=0` and `mem_we=0` while `rst` is low.
- Reset mid-burst abandons the burst with no partial write. The loader must reissue.
- Simultaneous `cpu_req` and `ld_valid` with `wait_cnt<MAX_WAIT`: the CPU wins.

## Structure
- Package `dmem_arb_pkg`: `arb_state_t` enum (`ARB_CPU`, `ARB_LOCK`) and default width constants.
- One sub-module, `sat_counter` (parameterized width/max, with clear and increment), instantiated for both `wait_cnt` and `burst_cnt`.

## Test plan
- CPU-only stream of str to 0x10 with data 0xAA, then ldr 0x10 → `mem_we` pulses, `cpu_rdata`=0xAA, `cpu_stall` never asserted.
- Loader write to 0x20 with data 0x55 while `cpu_req=0`, then loader read of 0x20 → `ld_ready`=1 immediately, and in the cycle after the read beat `ld_rvalid`=1 with `ld_rdata`=0x55.
- `cpu_req` and `ld_valid` both held high with `MAX_WAIT=4` → loader refused 4 cycles, granted on the 5th with `cpu_stall`=1 for that single cycle, then the CPU resumes.
- Locked burst of 10 requests with `BURST_MAX=8` under constant `cpu_req` → 8 consecutive loader beats with `cpu_stall` high, then state returns to `ARB_CPU` and the CPU runs.
- `rst` driven low in the middle of a locked burst → state `ARB_CPU`, `ld_rvalid`=0, `mem_we`=0 immediately; the next loader request is handled normally after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_BURST_MAX = 8;

    // ARB_CPU: CPU has priority; ARB_LOCK: loader owns memory for a burst.
    typedef enum logic {
        ARB_CPU  = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Bits needed to hold values 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // Count up on inc, hold at MAX, return to zero on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU and a loader/debug
// port. The CPU wins by default; an aging counter and locked bursts make sure
// the loader always progresses, and the CPU is stalled on every stolen cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_we,
    input  logic              ld_lock,
    input  logic [DATA_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W  = cnt_width(MAX_WAIT);
    localparam int BURST_W = cnt_width(BURST_MAX);

    localparam logic [WAIT_W-1:0]  WAIT_LIM   = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);
    localparam bit                 LOCK_OK    = (BURST_MAX > 1);

    arb_state_t         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic grant_ld;
    logic beat;
    logic lock_enter;
    logic lock_exit;

    // Loader wins when it owns a burst, when the CPU is idle, or once it has aged out.
    assign grant_ld  = ld_valid && ((state == ARB_LOCK) || !cpu_req || (wait_cnt == WAIT_LIM));
    assign ld_ready  = grant_ld && rst;
    assign beat      = ld_valid && ld_ready;
    assign cpu_stall = cpu_req && grant_ld;
    assign cpu_rdata = mem_rdata;

    // A burst ends on an unlocked beat, on its last allowed beat, or when the loader drops valid.
    assign lock_enter = (state == ARB_CPU) && beat && ld_lock && LOCK_OK;
    assign lock_exit  = (state == ARB_LOCK) &&
                        (!ld_valid || (beat && (!ld_lock || (burst_cnt == BURST_LAST))));

    // Steer the memory port to the granted requester; never write during reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req && cpu_we;
        if (grant_ld) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_we    = ld_we;
        end
        if (!rst) begin
            mem_we = 1'b0;
        end
    end

    // Refused-cycle count: restarts on every beat and whenever the loader is idle.
    sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (beat || !ld_valid),
        .inc   (1'b1),
        .count (wait_cnt)
    );

    // Beats taken in the current burst; the entering beat counts as the first.
    sat_counter #(
        .WIDTH (BURST_W),
        .MAX   (BURST_MAX)
    ) u_burst_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (lock_exit),
        .inc   (lock_enter || ((state == ARB_LOCK) && beat)),
        .count (burst_cnt)
    );

    // Arbitration state plus the registered loader read-return path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_CPU;
            ld_rdata  <= '0;
            ld_rvalid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample together.
            ld_rvalid <= beat && !ld_we;
            if (beat && !ld_we) begin
                ld_rdata <= mem_rdata;
            end
            if (lock_enter) begin
                state <= ARB_LOCK;
            end else if (lock_exit) begin
                state <= ARB_CPU;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural combinational-read dmem.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall;
    logic        ld_valid = 1'b0, ld_ready, ld_we = 1'b0, ld_lock = 1'b0;
    logic [31:0] ld_addr = '0, ld_wdata = '0, ld_rdata;
    logic        ld_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W    (32),
        .MAX_WAIT  (4),
        .BURST_MAX (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_we     (ld_we),
        .ld_lock   (ld_lock),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_rdata  (ld_rdata),
        .ld_rvalid (ld_rvalid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory model: combinational read, write at the rising edge.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and let it settle.
    task automatic cyc(input logic r,
                       input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                       input logic lv, input logic lw, input logic ll,
                       input logic [31:0] la, input logic [31:0] lwd);
        @(negedge clk);
        rst = r;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd;
        ld_valid = lv; ld_we = lw; ld_lock = ll; ld_addr = la; ld_wdata = lwd;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | i;

        // Reset: loader asks for a write with an idle CPU, nothing may happen.
        cyc(0, 0,0,32'h0,32'h0, 1,1,0,32'h30,32'h77);
        check("rst_ld_ready",  {31'b0, ld_ready},  32'h0);
        check("rst_mem_we",    {31'b0, mem_we},    32'h0);
        check("rst_ld_rvalid", {31'b0, ld_rvalid}, 32'h0);
        check("rst_ld_rdata",  ld_rdata,           32'h0);
        cyc(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
        check("rst_no_write", mem[8'h30], 32'hD000_0030);

        // CPU store then load of 0x10.
        cyc(1, 1,1,32'h10,32'hAA, 0,0,0,32'h0,32'h0);
        check("cpu_str_we",    {31'b0, mem_we},    32'h1);
        check("cpu_str_addr",  mem_addr,           32'h10);
        check("cpu_str_wdata", mem_wdata,          32'hAA);
        check("cpu_str_stall", {31'b0, cpu_stall}, 32'h0);
        cyc(1, 1,0,32'h10,32'h0, 0,0,0,32'h0,32'h0);
        check("cpu_ldr_we",    {31'b0, mem_we},    32'h0);
        check("cpu_ldr_rdata", cpu_rdata,          32'hAA);
        check("cpu_ldr_stall", {31'b0, cpu_stall}, 32'h0);

        // Loader write 0x55 to 0x20 with the CPU idle, then read it back.
        cyc(1, 0,0,32'h0,32'h0, 1,1,0,32'h20,32'h55);
        check("ldw_ready", {31'b0, ld_ready}, 32'h1);
        check("ldw_we",    {31'b0, mem_we},   32'h1);
        check("ldw_addr",  mem_addr,          32'h20);
        check("ldw_wdata", mem_wdata,         32'h55);
        cyc(1, 0,0,32'h0,32'h0, 1,0,0,32'h20,32'h0);
        check("ldr_ready",       {31'b0, ld_ready},  32'h1);
        check("ldw_no_rvalid",   {31'b0, ld_rvalid}, 32'h0);
        cyc(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
        check("ldr_rvalid", {31'b0, ld_rvalid}, 32'h1);
        check("ldr_rdata",  ld_rdata,           32'h55);
        cyc(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
        check("ldr_rvalid_pulse", {31'b0, ld_rvalid}, 32'h0);
        check("ldr_rdata_hold",   ld_rdata,           32'h55);

        // Aging: both request; four refusals, then one stolen cycle.
        for (int c = 0; c < 4; c++) begin
            cyc(1, 1,0,32'h10,32'h0, 1,0,0,32'h20,32'h0);
            check("age_refused", {31'b0, ld_ready},  32'h0);
            check("age_nostall", {31'b0, cpu_stall}, 32'h0);
            check("age_cpuaddr", mem_addr,           32'h10);
        end
        cyc(1, 1,0,32'h10,32'h0, 1,0,0,32'h20,32'h0);
        check("age_grant", {31'b0, ld_ready},  32'h1);
        check("age_stall", {31'b0, cpu_stall}, 32'h1);
        check("age_ldaddr", mem_addr,          32'h20);
        cyc(1, 1,0,32'h10,32'h0, 1,0,0,32'h20,32'h0);
        check("age_resume_ready", {31'b0, ld_ready},  32'h0);
        check("age_resume_stall", {31'b0, cpu_stall}, 32'h0);
        check("age_rvalid",       {31'b0, ld_rvalid}, 32'h1);
        check("age_rdata",        ld_rdata,           32'h55);
        cyc(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);

        // Locked burst of writes to 0x40.. under a constantly requesting CPU.
        for (int c = 0; c < 4; c++) begin
            cyc(1, 1,0,32'h10,32'h0, 1,1,1,32'h40,32'h100);
            check("burst_wait", {31'b0, ld_ready}, 32'h0);
        end
        for (int b = 0; b < 8; b++) begin
            cyc(1, 1,0,32'h10,32'h0, 1,1,1,32'h40 + b,32'h100 + b);
            check("burst_ready", {31'b0, ld_ready},  32'h1);
            check("burst_stall", {31'b0, cpu_stall}, 32'h1);
            check("burst_we",    {31'b0, mem_we},    32'h1);
            check("burst_addr",  mem_addr,           32'h40 + b);
        end
        cyc(1, 1,0,32'h10,32'h0, 1,1,1,32'h48,32'h108);
        check("burst_end_ready", {31'b0, ld_ready},  32'h0);
        check("burst_end_stall", {31'b0, cpu_stall}, 32'h0);
        check("burst_end_we",    {31'b0, mem_we},    32'h0);
        check("burst_end_addr",  mem_addr,           32'h10);
        cyc(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
        check("burst_mem_first", mem[8'h40], 32'h100);
        check("burst_mem_last",  mem[8'h47], 32'h107);
        check("burst_mem_past",  mem[8'h48], 32'hD000_0048);

        // Burst exit by an unlocked beat.
        cyc(1, 0,0,32'h0,32'h0, 1,0,1,32'h10,32'h0);
        check("unlk_enter", {31'b0, ld_ready}, 32'h1);
        cyc(1, 0,0,32'h0,32'h0, 1,0,0,32'h10,32'h0);
        check("unlk_beat",  {31'b0, ld_ready}, 32'h1);
        cyc(1, 1,0,32'h10,32'h0, 1,0,0,32'h20,32'h0);
        check("unlk_exit",  {31'b0, ld_ready}, 32'h0);

        // Burst exit by dropping valid.
        cyc(1, 0,0,32'h0,32'h0, 1,0,1,32'h10,32'h0);
        check("drop_enter", {31'b0, ld_ready}, 32'h1);
        cyc(1, 0,0,32'h0,32'h0, 0,0,1,32'h10,32'h0);
        cyc(1, 1,0,32'h10,32'h0, 1,0,1,32'h20,32'h0);
        check("drop_exit",  {31'b0, ld_ready}, 32'h0);
        cyc(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);

        // Reset in the middle of a locked read burst.
        for (int b = 0; b < 3; b++) begin
            cyc(1, 0,0,32'h0,32'h0, 1,0,1,32'h10,32'h0);
            check("rlk_ready", {31'b0, ld_ready}, 32'h1);
        end
        cyc(0, 1,0,32'h10,32'h0, 1,1,1,32'h11,32'hBAD);
        check("rlk_rvalid", {31'b0, ld_rvalid}, 32'h0);
        check("rlk_rdata",  ld_rdata,           32'h0);
        check("rlk_we",     {31'b0, mem_we},    32'h0);
        check("rlk_ready0", {31'b0, ld_ready},  32'h0);
        cyc(1, 1,0,32'h10,32'h0, 1,0,0,32'h20,32'h0);
        check("rlk_cpu_state", {31'b0, ld_ready},  32'h0);
        check("rlk_nostall",   {31'b0, cpu_stall}, 32'h0);
        check("rlk_no_write",  mem[8'h11],         32'hD000_0011);
        cyc(1, 0,0,32'h0,32'h0, 1,0,0,32'h20,32'h0);
        check("rlk_again_ready", {31'b0, ld_ready}, 32'h1);
        cyc(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
        check("rlk_again_rvalid", {31'b0, ld_rvalid}, 32'h1);
        check("rlk_again_rdata",  ld_rdata,           32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
